bpred_table_wr_ctrl: RTL and testbench

Write-port controller for the bimodal predictor table memory (256 x 36-bit word, 18 two-bit counters per word). It sequences table clearing after reset or on request. It buffers execute-stage counter-word updates in a small coalescing FIFO and arbitrates the single memory write port among clear, a debug/config writer and the update FIFO. It sits between the execute-stage update path and the table memory's write port.

---
 rtl/bpred_table_wr_ctrl.sv | 158 +++++++++++++++
 tb/tb_bpred_table_wr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_table_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpred_table_wr_ctrl
// Purpose  : Write-port controller for the bimodal predictor table. Clears the
//            table after reset or on request. Buffers execute-stage updates in
//            a small coalescing FIFO. Arbitrates the single write port among
//            clear, config writer and FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module bpred_table_wr_ctrl #(
  parameter int                TABLE_DEPTH = 256,
  parameter int                WORD_W      = 36,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [WORD_W-1:0] INIT_VALUE  = '0,
  localparam int               IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soin_bpredictor_stall,
  input  logic              execute_bpredictor_update,
  input  logic [IDX_W-1:0]  up_index,
  input  logic [WORD_W-1:0] up_word,
  input  logic              clear_req,
  input  logic              cfg_wr_req,
  input  logic [IDX_W-1:0]  cfg_wr_addr,
  input  logic [WORD_W-1:0] cfg_wr_data,
  output logic              cfg_wr_ack,
  output logic              mem_wren,
  output logic [IDX_W-1:0]  mem_wraddress,
  output logic [WORD_W-1:0] mem_data_w,
  output logic [3:0]        mem_byteena,
  output logic              clear_busy,
  output logic              upd_ready,
  output logic [15:0]       drop_count,
  output logic [15:0]       merge_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    clear_idx;
  logic [IDX_W-1:0]    fifo_idx  [FIFO_DEPTH];
  logic [WORD_W-1:0]   fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr, tail_ptr;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    last_addr;
  logic [WORD_W-1:0]   last_data;

  logic full, empty, clearing, in_run, arb_ok;
  logic upd_valid, accept, drop, merge, push;
  logic fifo_win, cfg_win;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign tail_ptr  = wr_ptr - PTR_W'(1);
  assign clearing  = (state == ST_CLEAR) & ~reset;
  assign in_run    = (state == ST_RUN) & ~reset;
  // A clear request suppresses the port for its cycle so queued writes are discarded.
  assign arb_ok    = in_run & ~clear_req;
  assign upd_valid = execute_bpredictor_update & ~soin_bpredictor_stall & ~reset;
  assign accept    = upd_valid & in_run & ~full;
  assign drop      = upd_valid & ((state == ST_CLEAR) | full);
  assign fifo_win  = arb_ok & (full | (~cfg_wr_req & ~empty));
  assign cfg_win   = arb_ok & ~full & cfg_wr_req;
  // Coalesce into the tail unless the tail is the head being popped now.
  assign merge     = accept & ~empty & (fifo_idx[tail_ptr] == up_index)
                   & ~(fifo_win & (count == CNT_W'(1)));
  assign push      = accept & ~merge;

  assign clear_busy  = (state == ST_CLEAR);
  assign upd_ready   = in_run & ~full;
  assign cfg_wr_ack  = cfg_win;
  assign mem_byteena = 4'hF;

  // Next-state selection for the clear/run sequencer.
  always_comb begin
    state_n = state;
    if (state == ST_CLEAR) begin
      if (clear_idx == IDX_W'(TABLE_DEPTH - 1)) state_n = ST_RUN;
    end else if (clear_req) begin
      state_n = ST_CLEAR;
    end
  end

  // Write-port mux: clear, FIFO head, config, or hold the last values.
  always_comb begin
    mem_wren      = clearing | fifo_win | cfg_win;
    mem_wraddress = last_addr;
    mem_data_w    = last_data;
    if (clearing) begin
      mem_wraddress = clear_idx;
      mem_data_w    = INIT_VALUE;
    end else if (fifo_win) begin
      mem_wraddress = fifo_idx[rd_ptr];
      mem_data_w    = fifo_word[rd_ptr];
    end else if (cfg_win) begin
      mem_wraddress = cfg_wr_addr;
      mem_data_w    = cfg_wr_data;
    end
  end

  // Sequencer state, clear index and last-driven port values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      state <= state_n;
      if (state == ST_CLEAR) clear_idx <= clear_idx + IDX_W'(1);
      else                   clear_idx <= '0;
      if (mem_wren) begin
        last_addr <= mem_wraddress;
        last_data <= mem_data_w;
      end
    end
  end

  // Update FIFO pointers and occupancy; a clear request flushes it.
  always_ff @(posedge clk) begin
    if (reset || (in_run && clear_req)) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_win) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(fifo_win);
    end
  end

  // FIFO storage: push writes a new slot, merge overwrites the tail word.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= up_index;
      fifo_word[wr_ptr] <= up_word;
    end else if (merge) begin
      fifo_word[tail_ptr] <= up_word;
    end
  end

  // Saturating drop and merge statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count  <= '0;
      merge_count <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF)    drop_count  <= drop_count + 16'd1;
      if (merge && merge_count != 16'hFFFF)  merge_count <= merge_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpred_table_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpred_table_wr_ctrl
// Purpose  : Directed self-checking bench for bpred_table_wr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpred_table_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, upd, clear_req, cfg_req;
  logic [7:0]  up_index, cfg_addr;
  logic [35:0] up_word, cfg_data;
  logic        cfg_ack, mem_wren, clear_busy, upd_ready;
  logic [7:0]  mem_wraddress;
  logic [35:0] mem_data_w;
  logic [3:0]  mem_byteena;
  logic [15:0] drop_count, merge_count;

  int checks   = 0;
  int failures = 0;

  bpred_table_wr_ctrl dut (
    .clk                       (clk),
    .reset                     (reset),
    .soin_bpredictor_stall     (stall),
    .execute_bpredictor_update (upd),
    .up_index                  (up_index),
    .up_word                   (up_word),
    .clear_req                 (clear_req),
    .cfg_wr_req                (cfg_req),
    .cfg_wr_addr               (cfg_addr),
    .cfg_wr_data               (cfg_data),
    .cfg_wr_ack                (cfg_ack),
    .mem_wren                  (mem_wren),
    .mem_wraddress             (mem_wraddress),
    .mem_data_w                (mem_data_w),
    .mem_byteena               (mem_byteena),
    .clear_busy                (clear_busy),
    .upd_ready                 (upd_ready),
    .drop_count                (drop_count),
    .merge_count               (merge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; upd = 0; clear_req = 0; cfg_req = 0;
    up_index = '0; up_word = '0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic drive_upd(input logic [7:0] idx, input logic [35:0] w);
    upd = 1; up_index = idx; up_word = w;
  endtask

  // Full 256-cycle clear sweep; optionally offers updates and a stray clear_req.
  task automatic clear_sweep(input bit with_offers);
    for (int i = 0; i < 256; i++) begin
      idle_inputs();
      if (with_offers) begin
        if (i >= 10 && i < 15) drive_upd(8'(i), 36'h1);
        if (i == 20) begin drive_upd(8'h99, 36'h2); stall = 1; end
        if (i == 100) clear_req = 1;
      end
      #1;
      check("clr_wren", mem_wren, 1);
      check("clr_addr", mem_wraddress, 64'(i));
      check("clr_data", mem_data_w, 0);
      check("clr_busy", clear_busy, 1);
      step();
    end
    idle_inputs();
    #1;
    check("clr_done_busy", clear_busy, 0);
    check("clr_done_ready", upd_ready, 1);
    check("clr_done_wren", mem_wren, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    #1;
    check("rst_wren", mem_wren, 0);
    check("rst_busy", clear_busy, 1);
    check("rst_ready", upd_ready, 0);
    check("rst_ack", cfg_ack, 0);
    step();
    check("rst_drop", drop_count, 0);
    check("rst_merge", merge_count, 0);
    check("rst_byteena", mem_byteena, 4'hF);
    reset = 0;

    // Initial clear with updates offered (5 counted, 1 stalled).
    clear_sweep(1'b1);
    check("clr_drops", drop_count, 5);
    step();

    // Single update, one-cycle latency.
    drive_upd(8'h12, 36'hA);
    #1;
    check("u1_ready", upd_ready, 1);
    step();
    idle_inputs();
    #1;
    check("u1_wren", mem_wren, 1);
    check("u1_addr", mem_wraddress, 8'h12);
    check("u1_data", mem_data_w, 36'hA);
    step();
    check("u1_idle_wren", mem_wren, 0);
    check("u1_hold_addr", mem_wraddress, 8'h12);
    check("u1_hold_data", mem_data_w, 36'hA);
    step();

    // cfg acked first, then three updates drain in order.
    cfg_req = 1; cfg_addr = 8'h05; cfg_data = 36'h55; drive_upd(8'h20, 36'h1);
    #1;
    check("t3_cfg_ack", cfg_ack, 1);
    check("t3_cfg_addr", mem_wraddress, 8'h05);
    check("t3_cfg_data", mem_data_w, 36'h55);
    step();
    cfg_req = 0; drive_upd(8'h21, 36'h2);
    #1;
    check("t3_u0_ack", cfg_ack, 0);
    check("t3_u0_addr", mem_wraddress, 8'h20);
    check("t3_u0_data", mem_data_w, 36'h1);
    step();
    drive_upd(8'h22, 36'h3);
    #1;
    check("t3_u1_addr", mem_wraddress, 8'h21);
    check("t3_u1_data", mem_data_w, 36'h2);
    step();
    idle_inputs();
    #1;
    check("t3_u2_wren", mem_wren, 1);
    check("t3_u2_addr", mem_wraddress, 8'h22);
    check("t3_u2_data", mem_data_w, 36'h3);
    step();
    check("t3_end_wren", mem_wren, 0);
    step();

    // cfg held while the FIFO fills; full head beats cfg; overflow dropped.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      cfg_req = 1; cfg_addr = 8'h07; cfg_data = 36'h77;
      drive_upd(8'(8'h31 + i), 36'(36'h11 + i));
      #1;
      check("t4_fill_ack", cfg_ack, 1);
      check("t4_fill_addr", mem_wraddress, 8'h07);
      step();
    end
    drive_upd(8'h35, 36'h15);
    #1;
    check("t4_full_ready", upd_ready, 0);
    check("t4_full_ack", cfg_ack, 0);
    check("t4_full_addr", mem_wraddress, 8'h31);
    check("t4_full_data", mem_data_w, 36'h11);
    step();
    upd = 0;
    #1;
    check("t4_cfg_ack", cfg_ack, 1);
    check("t4_cfg_addr", mem_wraddress, 8'h07);
    step();
    idle_inputs();
    for (int i = 1; i < 4; i++) begin
      #1;
      check("t4_drain_wren", mem_wren, 1);
      check("t4_drain_addr", mem_wraddress, 64'(8'h31 + i));
      check("t4_drain_data", mem_data_w, 64'(36'h11 + i));
      step();
    end
    check("t4_end_wren", mem_wren, 0);
    check("t4_drops", drop_count, 6);
    step();

    // Two updates to the same index coalesce while cfg holds the port.
    cfg_req = 1; cfg_addr = 8'h08; cfg_data = 36'h88; drive_upd(8'h40, 36'h1);
    step();
    drive_upd(8'h40, 36'h2);
    #1;
    check("t5_cfg_ack", cfg_ack, 1);
    step();
    idle_inputs();
    #1;
    check("t5_merge", merge_count, 1);
    check("t5_wren", mem_wren, 1);
    check("t5_addr", mem_wraddress, 8'h40);
    check("t5_data", mem_data_w, 36'h2);
    step();
    check("t5_end_wren", mem_wren, 0);
    step();

    // clear_req with three queued entries: flushed, full re-clear.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      cfg_req = 1; cfg_addr = 8'h09; cfg_data = 36'h99;
      drive_upd(8'(8'h50 + i), 36'(36'h50 + i));
      step();
    end
    idle_inputs();
    clear_req = 1;
    #1;
    check("t6_req_wren", mem_wren, 0);
    check("t6_req_ack", cfg_ack, 0);
    step();
    clear_sweep(1'b0);
    step();
    check("t6_post_wren", mem_wren, 0);
    check("t6_drops", drop_count, 6);
    check("t6_merge", merge_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
